pool_window_feeder: RTL and testbench

- Producer and consumer for the max-pool stage.
- Reads a K×K-window-ordered stream of R/G/B activations from a feature-map RAM and drives it into the pooling unit (en, Size, D_in_R/G/B).
- Captures each pooled result and writes it to an output-map RAM.
- Sits between a conv-layer output buffer and the next layer's input buffer; non-overlapping windows, stride = K.

---
 rtl/pool_pkg.sv | 23 ++
 rtl/pool_addr_gen.sv | 73 +++++++
 rtl/pool_window_feeder.sv | 148 ++++++++++++++
 tb/tb_pool_window_feeder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared types and limits for the max-pool window feeder.
// Holds the FSM encoding and the legal kernel range.
package pool_pkg;
   localparam int DATA_W_DEF = 16;
   localparam int K_MIN = 2;
   localparam int K_MAX = 7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRIME,
      S_STREAM,
      S_WRITE,
      S_FIN
   } state_t;

   function automatic logic cfg_ok(
      input int kk,
      input int mw,
      input int mh
   );
      return kk >= K_MIN && kk <= K_MAX && mw >= kk && mh >= kk;
   endfunction
endpackage

// File: rtl/pool_addr_gen.sv
// Window/element counters for the pool feeder.
// Produces source read addresses and output write index.
module pool_addr_gen #(
   parameter int ADDR_W = 12,
   parameter int DIM_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              step,
   input  logic              next_window,
   input  logic [2:0]        k,
   input  logic [DIM_W-1:0]  map_width,
   input  logic [DIM_W-1:0]  out_w,
   input  logic [DIM_W-1:0]  out_h,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              last_elem,
   output logic              last_window
);
   logic [2:0]        kx, ky;
   logic [DIM_W-1:0]  ox, oy;
   logic [ADDR_W-1:0] row, col, wr_q;
   logic              lw_q, ox_end, oy_end;

   assign ox_end = ox == out_w - DIM_W'(1);
   assign oy_end = oy == out_h - DIM_W'(1);

   assign row = ADDR_W'(oy) * ADDR_W'(k) + ADDR_W'(ky);
   assign col = ADDR_W'(ox) * ADDR_W'(k) + ADDR_W'(kx);
   assign rd_addr = row * ADDR_W'(map_width) + col;
   assign wr_addr = wr_q;
   assign last_window = lw_q;
   // element counter has wrapped: the window's final datum is on rd_data
   assign last_elem = kx == 3'd0 && ky == 3'd0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kx   <= '0;
         ky   <= '0;
         ox   <= '0;
         oy   <= '0;
         wr_q <= '0;
         lw_q <= 1'b0;
      end else if (clr) begin
         kx   <= '0;
         ky   <= '0;
         ox   <= '0;
         oy   <= '0;
         wr_q <= '0;
         lw_q <= 1'b0;
      end else begin
         if (step) begin
            if (kx == k - 3'd1) begin
               kx <= '0;
               ky <= (ky == k - 3'd1) ? 3'd0 : ky + 3'd1;
            end else begin
               kx <= kx + 3'd1;
            end
         end
         if (next_window) begin
            wr_q <= ADDR_W'(oy) * ADDR_W'(out_w) + ADDR_W'(ox);
            lw_q <= ox_end && oy_end;
            if (ox_end) begin
               ox <= '0;
               oy <= oy_end ? '0 : oy + DIM_W'(1);
            end else begin
               ox <= ox + DIM_W'(1);
            end
         end
      end
   end
endmodule

// File: rtl/pool_window_feeder.sv
// Streams KxK windows from a feature-map RAM into the pooling
// unit and writes each pooled result to the output-map RAM.
module pool_window_feeder
   import pool_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = 12,
   parameter int DIM_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DIM_W-1:0]  map_width,
   input  logic [DIM_W-1:0]  map_height,
   input  logic [2:0]        k,
   output logic              busy,
   output logic              done,
   output logic              cfg_err,
   output logic              ack_err,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data_R,
   input  logic [DATA_W-1:0] rd_data_G,
   input  logic [DATA_W-1:0] rd_data_B,
   output logic              en,
   output logic [5:0]        Size,
   output logic [DATA_W-1:0] D_in_R,
   output logic [DATA_W-1:0] D_in_G,
   output logic [DATA_W-1:0] D_in_B,
   input  logic [DATA_W-1:0] Pool_out_R,
   input  logic [DATA_W-1:0] Pool_out_G,
   input  logic [DATA_W-1:0] Pool_out_B,
   input  logic              pool_ack,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data_R,
   output logic [DATA_W-1:0] wr_data_G,
   output logic [DATA_W-1:0] wr_data_B
);
   state_t           state, state_nx;
   logic [2:0]       k_q, k_div;
   logic [DIM_W-1:0] mw_q, ow_q, oh_q, ow_nx, oh_nx;
   logic             bad_q, ack_err_q, accept, good;
   logic             last_elem, last_window, step, next_window;

   assign accept = state == S_IDLE && start;
   assign good = cfg_ok(int'(k), int'(map_width), int'(map_height));
   // keep the divider defined for k=0; that config is rejected anyway
   assign k_div = (k == 3'd0) ? 3'd1 : k;
   assign ow_nx = map_width / DIM_W'(k_div);
   assign oh_nx = map_height / DIM_W'(k_div);

   assign Size = {3'b000, k_q} * {3'b000, k_q};
   assign ack_err = ack_err_q;
   assign D_in_R = rd_data_R;
   assign D_in_G = rd_data_G;
   assign D_in_B = rd_data_B;
   assign wr_data_R = Pool_out_R;
   assign wr_data_G = Pool_out_G;
   assign wr_data_B = Pool_out_B;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_q       <= '0;
         mw_q      <= '0;
         ow_q      <= '0;
         oh_q      <= '0;
         bad_q     <= 1'b0;
         ack_err_q <= 1'b0;
      end else if (accept) begin
         k_q       <= k;
         mw_q      <= map_width;
         ow_q      <= ow_nx;
         oh_q      <= oh_nx;
         bad_q     <= !good;
         ack_err_q <= 1'b0;
      end else if (state == S_STREAM && pool_ack != last_elem) begin
         ack_err_q <= 1'b1;
      end
   end

   always_comb begin
      state_nx    = state;
      busy        = 1'b0;
      done        = 1'b0;
      cfg_err     = 1'b0;
      en          = 1'b0;
      wr_en       = 1'b0;
      step        = 1'b0;
      next_window = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) state_nx = good ? S_PRIME : S_FIN;
         end
         S_PRIME: begin
            busy     = 1'b1;
            step     = 1'b1;
            state_nx = S_STREAM;
         end
         S_STREAM: begin
            busy = 1'b1;
            en   = 1'b1;
            if (last_elem) begin
               next_window = 1'b1;
               state_nx    = S_WRITE;
            end else begin
               step = 1'b1;
            end
         end
         // also primes the first read of the next window
         S_WRITE: begin
            busy     = 1'b1;
            wr_en    = 1'b1;
            step     = 1'b1;
            state_nx = last_window ? S_FIN : S_STREAM;
         end
         S_FIN: begin
            done     = 1'b1;
            cfg_err  = bad_q;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   pool_addr_gen #(
      .ADDR_W(ADDR_W),
      .DIM_W (DIM_W)
   ) u_addr (
      .clk        (clk),
      .rst        (rst),
      .clr        (accept),
      .step       (step),
      .next_window(next_window),
      .k          (k_q),
      .map_width  (mw_q),
      .out_w      (ow_q),
      .out_h      (oh_q),
      .rd_addr    (rd_addr),
      .wr_addr    (wr_addr),
      .last_elem  (last_elem),
      .last_window(last_window)
   );
endmodule

// File: tb/tb_pool_window_feeder.sv
// Scoreboard bench for pool_window_feeder with RAM and
// running-max pooling-unit models.
module tb_pool_window_feeder;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [5:0]  map_width = '0;
   logic [5:0]  map_height = '0;
   logic [2:0]  k = '0;
   logic        busy, done, cfg_err, ack_err, en, wr_en;
   logic [11:0] rd_addr, wr_addr;
   logic [5:0]  Size;
   logic [15:0] rd_data_R = '0, rd_data_G = '0, rd_data_B = '0;
   logic [15:0] D_in_R, D_in_G, D_in_B;
   logic [15:0] acc_r = '0, acc_g = '0, acc_b = '0;
   logic [15:0] wr_data_R, wr_data_G, wr_data_B;
   logic        pool_ack;

   typedef struct {
      int a;
      int r;
      int g;
      int b;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   mode = 0;
   int   exp_size = 0;
   int   pcnt = 0;
   bit   ack_zero = 1'b0;
   int   nwr = 0, nen = 0, size_bad = 0, col_bad = 0;
   int   ack_w0 = -1;

   always #5 clk = ~clk;

   pool_window_feeder dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .map_width (map_width),
      .map_height(map_height),
      .k         (k),
      .busy      (busy),
      .done      (done),
      .cfg_err   (cfg_err),
      .ack_err   (ack_err),
      .rd_addr   (rd_addr),
      .rd_data_R (rd_data_R),
      .rd_data_G (rd_data_G),
      .rd_data_B (rd_data_B),
      .en        (en),
      .Size      (Size),
      .D_in_R    (D_in_R),
      .D_in_G    (D_in_G),
      .D_in_B    (D_in_B),
      .Pool_out_R(acc_r),
      .Pool_out_G(acc_g),
      .Pool_out_B(acc_b),
      .pool_ack  (pool_ack),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data_R (wr_data_R),
      .wr_data_G (wr_data_G),
      .wr_data_B (wr_data_B)
   );

   function automatic int ram_val(input int a);
      if (mode == 1) return 7 * (a / 5) + 3 * (a % 5);
      return a;
   endfunction

   always @(posedge clk) begin
      rd_data_R <= 16'(ram_val(int'(rd_addr)));
      rd_data_G <= 16'(ram_val(int'(rd_addr)) + 1000);
      rd_data_B <= 16'(ram_val(int'(rd_addr)) + 2000);
   end

   // pooling unit: running max, restarted by the en-low gap
   always @(posedge clk) begin
      if (en) begin
         acc_r <= (pcnt == 0 || D_in_R > acc_r) ? D_in_R : acc_r;
         acc_g <= (pcnt == 0 || D_in_G > acc_g) ? D_in_G : acc_g;
         acc_b <= (pcnt == 0 || D_in_B > acc_b) ? D_in_B : acc_b;
         pcnt  <= pcnt + 1;
      end else begin
         pcnt <= 0;
      end
   end
   assign pool_ack = !ack_zero && en && (pcnt == exp_size - 1);

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (wr_en) begin
            if (nwr == 0) ack_w0 = int'(ack_err);
            nwr++;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL write_unexpected: addr %0d data %0d, none expected",
                        wr_addr, wr_data_R);
            end else begin
               e = sb.pop_front();
               if (int'(wr_addr) != e.a || int'(wr_data_R) != e.r ||
                   int'(wr_data_G) != e.g || int'(wr_data_B) != e.b) begin
                  errors++;
                  $display("FAIL write: got a=%0d rgb=%0d/%0d/%0d want a=%0d rgb=%0d/%0d/%0d",
                           wr_addr, wr_data_R, wr_data_G, wr_data_B,
                           e.a, e.r, e.g, e.b);
               end
            end
         end
         if (en) nen++;
         if (busy && int'(Size) != exp_size) size_bad++;
         if (busy && mode == 1 && (int'(rd_addr) % 5) >= 3) col_bad++;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic push(input int a, input int v);
      sb.push_back('{a, v, v + 1000, v + 2000});
   endtask

   task automatic run_pass(input string nm, input int mw, input int mh,
                           input int kk, input int lat, input int cfg,
                           input int aerr, input int nw, input int ne,
                           input bit poke);
      int n;
      int cfg_seen, aerr_seen;
      map_width  = 6'(mw);
      map_height = 6'(mh);
      k          = 3'(kk);
      nwr = 0;
      nen = 0;
      size_bad = 0;
      ack_w0 = -1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n = 1;
      chk({nm, "_ack_clear"}, int'(ack_err), 0);
      while (!done && n < 400) begin
         start = poke && n == 5;
         @(posedge clk);
         #1;
         n++;
      end
      start = 1'b0;
      cfg_seen  = int'(cfg_err);
      aerr_seen = int'(ack_err);
      chk({nm, "_latency"}, done ? n : -1, lat);
      chk({nm, "_cfg_err"}, cfg_seen, cfg);
      chk({nm, "_ack_err"}, aerr_seen, aerr);
      @(posedge clk);
      #1;
      chk({nm, "_done_pulse"}, int'(done), 0);
      chk({nm, "_writes"}, nwr, nw);
      chk({nm, "_en_cycles"}, nen, ne);
      chk({nm, "_sb_left"}, sb.size(), 0);
      chk({nm, "_size"}, size_bad, 0);
      if (nw > 0) chk({nm, "_ack_w0"}, ack_w0, aerr);
      sb.delete();
   endtask

   initial begin
      int n;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctrl", int'({busy, done, cfg_err, ack_err, en, wr_en}), 0);
      chk("rst_addr", int'(|rd_addr | |wr_addr | |Size), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      mode = 0;
      exp_size = 4;
      push(0, 5); push(1, 7); push(2, 13); push(3, 15);
      run_pass("k2_4x4", 4, 4, 2, 22, 0, 0, 4, 16, 1'b0);

      mode = 1;
      exp_size = 9;
      col_bad = 0;
      push(0, 20); push(1, 41);
      run_pass("k3_5x7", 5, 7, 3, 22, 0, 0, 2, 18, 1'b0);
      chk("k3_cols", col_bad, 0);

      mode = 0;
      run_pass("k1", 4, 4, 1, 1, 1, 0, 0, 0, 1'b0);
      run_pass("k4_w3", 3, 8, 4, 1, 1, 0, 0, 0, 1'b0);

      exp_size = 4;
      ack_zero = 1'b1;
      push(0, 5); push(1, 7); push(2, 13); push(3, 15);
      run_pass("ack0", 4, 4, 2, 22, 0, 1, 4, 16, 1'b0);
      ack_zero = 1'b0;
      push(0, 5); push(1, 7); push(2, 13); push(3, 15);
      run_pass("ack_ok", 4, 4, 2, 22, 0, 0, 4, 16, 1'b0);

      push(0, 5); push(1, 7); push(2, 13); push(3, 15);
      map_width = 6'd4;
      map_height = 6'd4;
      k = 3'd2;
      nwr = 0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n = 0;
      while (nwr < 1 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("mid_first_write", nwr, 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_ctrl", int'({busy, done, cfg_err, ack_err, en, wr_en}), 0);
      chk("mid_rst_addr", int'(|rd_addr | |wr_addr | |Size), 0);
      repeat (4) @(posedge clk);
      #1;
      chk("mid_rst_writes", nwr, 1);
      sb.delete();
      rst = 1'b0;
      @(posedge clk);
      #1;

      push(0, 5); push(1, 7); push(2, 13); push(3, 15);
      run_pass("after_rst", 4, 4, 2, 22, 0, 0, 4, 16, 1'b0);

      push(0, 5); push(1, 7); push(2, 13); push(3, 15);
      run_pass("busy_start", 4, 4, 2, 22, 0, 0, 4, 16, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
